// File: rtl/daq_conv_sequencer_pkg.sv
// daq_conv_sequencer_pkg: shared state encodings and mode constants for the conversion-start sequencer.
package daq_conv_sequencer_pkg;
   typedef enum logic [1:0] {ST_IDLE, ST_COUNT, ST_WAIT_BUSY, ST_TRIGGER} state_t;
   localparam logic [1:0] MODE_CONT   = 2'b00;
   localparam logic [1:0] MODE_SINGLE = 2'b01;
   localparam logic [1:0] MODE_BURST  = 2'b10;
endpackage

// File: rtl/daq_conv_sequencer_busy_sync.sv
// daq_conv_sequencer_busy_sync: per-line busy synchroniser; the OR is taken only after the last stage.
module daq_conv_sequencer_busy_sync #(
   parameter int N_ADC       = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic [N_ADC-1:0] i_busy,
   output logic             o_busy_s
);
   logic [SYNC_STAGES-1:0][N_ADC-1:0] r_sync;
   always_ff @(posedge clk_i or posedge reset_i)
      if (reset_i) r_sync <= '0;
      else         r_sync <= {r_sync[SYNC_STAGES-2:0], i_busy};
   assign o_busy_s = |r_sync[SYNC_STAGES-1];
endmodule

// File: rtl/daq_conv_sequencer.sv
// daq_conv_sequencer: drives active-low conversion-start pulses to ganged ADCs,
// with period/width control, continuous/single/burst modes, busy gating and busy timeout.
module daq_conv_sequencer
   import daq_conv_sequencer_pkg::*;
#(
   parameter int N_ADC       = 4,
   parameter int CNT_W       = 16,
   parameter int SYNC_STAGES = 2,
   parameter int BUSY_TMO    = 1000
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             en_i,
   input  logic             start_i,
   input  logic             stop_i,
   input  logic [1:0]       mode_i,
   input  logic [CNT_W-1:0] period_i,
   input  logic [CNT_W-1:0] pulse_i,
   input  logic [CNT_W-1:0] burst_len_i,
   input  logic [N_ADC-1:0] busy_i,
   output logic             conv_clk_o,
   output logic             running_o,
   output logic             done_o,
   output logic             timeout_o,
   output logic [CNT_W-1:0] sample_cnt_o
);
   state_t           r_state, w_nxt;
   logic [1:0]       r_mode;
   logic [CNT_W-1:0] r_p, r_w, r_blen, r_cnt, r_smp, r_tmo, w_w_eff, w_p_eff;
   logic             r_stop, r_conv, r_done, r_tmo_flag;
   logic             w_busy_s, w_start, w_trig_end, w_last, w_done, w_enter_trig, w_retry;

   daq_conv_sequencer_busy_sync #(.N_ADC(N_ADC), .SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .i_busy  (busy_i),
      .o_busy_s(w_busy_s)
   );

   assign w_start    = (r_state == ST_IDLE) && en_i && start_i;
   assign w_w_eff    = (pulse_i == '0) ? CNT_W'(1) : pulse_i;
   assign w_p_eff    = (period_i > w_w_eff) ? period_i : w_w_eff + 1'b1;
   // The period counter keeps running through the pulse, so the pulse ends after W cycles of it.
   assign w_trig_end = (r_state == ST_TRIGGER) && (r_cnt == r_p - r_w);
   assign w_last     = (r_mode == MODE_SINGLE) || ((r_mode == MODE_BURST) && (r_smp >= r_blen));

   always_comb begin
      w_nxt  = r_state;
      w_done = 1'b0;
      if (!en_i) w_nxt = ST_IDLE;
      else case (r_state)
         ST_IDLE:      if (start_i) w_nxt = ST_COUNT;
         ST_COUNT:     if (stop_i) begin
                          w_nxt  = ST_IDLE;
                          w_done = 1'b1;
                       end else if (r_cnt == '0) w_nxt = w_busy_s ? ST_WAIT_BUSY : ST_TRIGGER;
         ST_WAIT_BUSY: if (stop_i) begin
                          w_nxt  = ST_IDLE;
                          w_done = 1'b1;
                       end else if (!w_busy_s) w_nxt = ST_TRIGGER;
                       else if (r_tmo == CNT_W'(BUSY_TMO - 1)) w_nxt = ST_COUNT;
         ST_TRIGGER:   if (w_trig_end) begin
                          w_nxt  = (stop_i || r_stop || w_last) ? ST_IDLE : ST_COUNT;
                          w_done = stop_i || r_stop || w_last;
                       end
         default:      w_nxt = ST_IDLE;
      endcase
   end

   assign w_enter_trig = (w_nxt == ST_TRIGGER) && (r_state != ST_TRIGGER);
   assign w_retry      = (r_state == ST_WAIT_BUSY) && (w_nxt == ST_COUNT);

   always_ff @(posedge clk_i or posedge reset_i)
      if (reset_i) begin
         r_state    <= ST_IDLE;
         r_mode     <= '0;
         r_p        <= '0;
         r_w        <= '0;
         r_blen     <= '0;
         r_cnt      <= '0;
         r_smp      <= '0;
         r_tmo      <= '0;
         r_stop     <= 1'b0;
         r_conv     <= 1'b1;
         r_done     <= 1'b0;
         r_tmo_flag <= 1'b0;
      end else begin
         r_state    <= w_nxt;
         r_conv     <= (w_nxt != ST_TRIGGER);
         r_done     <= w_done;
         r_stop     <= (w_nxt == ST_TRIGGER) && (r_stop || stop_i);
         r_cnt      <= w_start ? w_p_eff - 1'b1 :
                       (w_enter_trig || w_retry) ? r_p - 1'b1 :
                       (r_cnt != '0) ? r_cnt - 1'b1 : r_cnt;
         r_tmo      <= (r_state == ST_WAIT_BUSY) ? r_tmo + 1'b1 : '0;
         r_tmo_flag <= w_start ? 1'b0 : (w_retry ? 1'b1 : r_tmo_flag);
         r_smp      <= w_start ? '0 : (w_enter_trig ? r_smp + 1'b1 : r_smp);
         if (w_start) begin
            r_mode <= mode_i;
            r_w    <= w_w_eff;
            r_p    <= w_p_eff;
            r_blen <= (burst_len_i == '0) ? CNT_W'(1) : burst_len_i;
         end
      end

   assign conv_clk_o   = r_conv;
   assign running_o    = (r_state != ST_IDLE);
   assign done_o       = r_done;
   assign timeout_o    = r_tmo_flag;
   assign sample_cnt_o = r_smp;
endmodule

// File: tb/tb_daq_conv_sequencer.sv
// tb_daq_conv_sequencer: scoreboard bench; expected fall/done cycles are queued at arm time
// and popped by a monitor as the DUT produces them.
module tb_daq_conv_sequencer;
   import daq_conv_sequencer_pkg::*;
   localparam int N = 4, CW = 16;
   logic          clk_i = 0, reset_i = 1, en_i = 0, start_i = 0, stop_i = 0;
   logic [1:0]    mode_i = 0;
   logic [CW-1:0] period_i = 0, pulse_i = 0, burst_len_i = 0;
   logic [N-1:0]  busy_i = 0;
   logic          conv_clk_o, running_o, done_o, timeout_o;
   logic [CW-1:0] sample_cnt_o;
   int n_chk = 0, n_fail = 0, cyc = 0, fall_cyc = 0, exp_w = 0, c0 = 0;
   int q_fall[$], q_done[$];
   logic prev_conv = 1;

   daq_conv_sequencer #(.N_ADC(N), .CNT_W(CW), .SYNC_STAGES(2), .BUSY_TMO(20)) dut (
      .clk_i(clk_i), .reset_i(reset_i), .en_i(en_i), .start_i(start_i), .stop_i(stop_i),
      .mode_i(mode_i), .period_i(period_i), .pulse_i(pulse_i), .burst_len_i(burst_len_i),
      .busy_i(busy_i), .conv_clk_o(conv_clk_o), .running_o(running_o), .done_o(done_o),
      .timeout_o(timeout_o), .sample_cnt_o(sample_cnt_o)
   );

   always #5 clk_i = ~clk_i;
   always @(posedge clk_i) cyc <= cyc + 1;

   task automatic check(input string tag, input int got, input int exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0d exp=%0d (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   always @(negedge clk_i) begin
      if (prev_conv && !conv_clk_o) begin
         fall_cyc = cyc;
         check("fall_pending", 32'(q_fall.size() != 0), 1);
         if (q_fall.size() != 0) check("fall_cycle", cyc, q_fall.pop_front());
      end
      if (!prev_conv && conv_clk_o) check("pulse_width", cyc - fall_cyc, exp_w);
      if (done_o === 1'b1) begin
         check("done_pending", 32'(q_done.size() != 0), 1);
         if (q_done.size() != 0) check("done_cycle", cyc, q_done.pop_front());
      end
      prev_conv = conv_clk_o;
   end

   task automatic upto(input int t);
      while (cyc < t) @(negedge clk_i);
   endtask

   task automatic arm(input logic [1:0] m, input int p, input int w, input int b);
      mode_i = m; period_i = CW'(p); pulse_i = CW'(w); burst_len_i = CW'(b);
      start_i = 1;
      @(negedge clk_i);
      start_i = 0;
   endtask

   task automatic stop_pulse;
      stop_i = 1;
      @(negedge clk_i);
      stop_i = 0;
   endtask

   initial begin
      upto(2);
      check("rst_conv", 32'(conv_clk_o), 1);
      check("rst_running", 32'(running_o), 0);
      check("rst_done", 32'(done_o), 0);
      check("rst_timeout", 32'(timeout_o), 0);
      check("rst_cnt", 32'(sample_cnt_o), 0);
      reset_i = 0; en_i = 1;
      upto(4);
      // continuous P=10 W=3, stop during the third pulse
      exp_w = 3; c0 = cyc;
      for (int i = 0; i < 3; i++) q_fall.push_back(c0 + 11 + 10 * i);
      q_done.push_back(c0 + 34);
      arm(MODE_CONT, 10, 3, 0);
      check("t1_running", 32'(running_o), 1);
      upto(c0 + 32);
      stop_pulse();
      upto(c0 + 40);
      check("t1_cnt", 32'(sample_cnt_o), 3);
      check("t1_idle", 32'(running_o), 0);
      // burst of 4, P=8 W=2
      exp_w = 2; c0 = cyc;
      for (int i = 0; i < 4; i++) q_fall.push_back(c0 + 9 + 8 * i);
      q_done.push_back(c0 + 35);
      arm(MODE_BURST, 8, 2, 4);
      upto(c0 + 50);
      check("t2_cnt", 32'(sample_cnt_o), 4);
      check("t2_idle", 32'(running_o), 0);
      // busy stall on line 2 delays the second trigger
      exp_w = 3; c0 = cyc;
      q_fall.push_back(c0 + 11); q_fall.push_back(c0 + 27); q_fall.push_back(c0 + 37);
      q_done.push_back(c0 + 41);
      arm(MODE_CONT, 10, 3, 0);
      upto(c0 + 15); busy_i[2] = 1;
      upto(c0 + 24); busy_i[2] = 0;
      check("t3_wait_running", 32'(running_o), 1);
      upto(c0 + 40);
      stop_pulse();
      upto(c0 + 45);
      check("t3_cnt", 32'(sample_cnt_o), 3);
      check("t3_timeout", 32'(timeout_o), 0);
      // busy line 0 stuck: timeout after 20 cycles, retry succeeds once released
      busy_i[0] = 1;
      upto(cyc + 3);
      exp_w = 3; c0 = cyc;
      q_fall.push_back(c0 + 41);
      q_done.push_back(c0 + 46);
      arm(MODE_CONT, 10, 3, 0);
      upto(c0 + 30);
      check("t4_timeout_pre", 32'(timeout_o), 0);
      upto(c0 + 31);
      check("t4_timeout_set", 32'(timeout_o), 1);
      upto(c0 + 35); busy_i[0] = 0;
      upto(c0 + 45);
      stop_pulse();
      upto(c0 + 48);
      check("t4_timeout_sticky", 32'(timeout_o), 1);
      check("t4_cnt", 32'(sample_cnt_o), 1);
      // en_i dropped mid-pulse: truncated, no done, timeout cleared by the start
      exp_w = 1; c0 = cyc;
      q_fall.push_back(c0 + 11);
      arm(MODE_CONT, 10, 3, 0);
      check("t5_timeout_clr", 32'(timeout_o), 0);
      upto(c0 + 11); en_i = 0;
      upto(c0 + 12);
      check("t5_conv_high", 32'(conv_clk_o), 1);
      check("t5_idle", 32'(running_o), 0);
      check("t5_cnt_held", 32'(sample_cnt_o), 1);
      en_i = 1;
      upto(c0 + 14);
      // asynchronous reset mid-COUNT
      exp_w = 3; c0 = cyc;
      q_fall.push_back(c0 + 11);
      arm(MODE_CONT, 10, 3, 0);
      upto(c0 + 15);
      #2 reset_i = 1;
      #1;
      check("t5_rst_conv", 32'(conv_clk_o), 1);
      check("t5_rst_running", 32'(running_o), 0);
      check("t5_rst_cnt", 32'(sample_cnt_o), 0);
      check("t5_rst_done", 32'(done_o), 0);
      @(negedge clk_i); reset_i = 0;
      upto(cyc + 2);
      // degenerate config W=0,P=1 -> W=1,P=2; mid-run start/config changes ignored
      exp_w = 1; c0 = cyc;
      for (int i = 0; i < 8; i++) q_fall.push_back(c0 + 3 + 2 * i);
      q_done.push_back(c0 + 18);
      arm(MODE_CONT, 1, 0, 0);
      upto(c0 + 6);
      mode_i = MODE_SINGLE; period_i = 20; pulse_i = 5;
      start_i = 1; @(negedge clk_i); start_i = 0;
      upto(c0 + 17);
      stop_pulse();
      upto(c0 + 25);
      check("t6_cnt", 32'(sample_cnt_o), 8);
      check("t6_idle", 32'(running_o), 0);
      // single shot P=5 W=2
      exp_w = 2; c0 = cyc;
      q_fall.push_back(c0 + 6);
      q_done.push_back(c0 + 8);
      arm(MODE_SINGLE, 5, 2, 7);
      upto(c0 + 20);
      check("t7_cnt", 32'(sample_cnt_o), 1);
      check("t7_idle", 32'(running_o), 0);
      check("fall_q_empty", q_fall.size(), 0);
      check("done_q_empty", q_done.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end
endmodule
